uart_rx_cfg: RTL
================

# uart_rx_cfg

Runtime-configurable UART receiver, the next generation of the fixed-format receiver in the `UART` block. Supports 5..`DBIT_MAX` data bits, none/even/odd parity and 1 or 2 stop bits. Uses 3-sample majority voting per bit and reports parity, frame and break errors. Sits between the `RsRx` pin and the rx FIFO / command interface. Integrates its own baud-tick generator.

## Interface
- `DBIT_MAX`, 8, maximum data bits; legal 5..15
- `OVS`, 16, oversampling ticks per bit; even, ≥8
- `DVSR`, 326, clock cycles per oversampling tick
- `DVSR_BIT`, 9, width of baud counter; 2^DVSR_BIT ≥ DVSR
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `i_rx`  in  1  serial line, asynchronous, idle high
- `i_cfg_dbit`  in  4  data-bit count; <5 treated as 5, >DBIT_MAX as DBIT_MAX
- `i_cfg_parity`  in  2  00 none, 01 even, 10 odd, 11 none
- `i_cfg_stop`  in  1  0 = 1 stop bit, 1 = 2 stop bits
- `o_data`  out  DBIT_MAX  received word, LSB = first bit, unused MSBs zero
- `o_valid`  out  1  one-cycle pulse, frame complete
- `o_parity_err`  out  1  parity mismatch in last frame
- `o_frame_err`  out  1  stop bit sampled low in last frame
- `o_break`  out  1  break condition in last frame
- `o_busy`  out  1  high in any state except IDLE

## Operation
- `i_rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- Baud counter is free-running 0..DVSR-1. `tick` = 1 for one clk when count == DVSR-1. Reset value 0.
- Per-bit tick counter `s` counts 0..OVS-1. `rx_s` is sampled on ticks `s` = OVS/2-1, OVS/2, OVS/2+1. Majority of the 3 samples = bit value. Bit is evaluated on the tick with `s` == OVS-1.
- Config is latched on the start-bit tick. Changes during a frame are ignored.
- States:
  - WAIT_IDLE (reset state): on a tick with `rx_s` == 1, go to IDLE.
  - IDLE: on a tick with `rx_s` == 0, go to START with `s` = 0.
  - START: at bit end, majority 1 (false start) → IDLE, no output. Otherwise → DATA, `n` = 0.
  - DATA: shift majority in LSB-first. When `n` == dbit-1: → PARITY if parity enabled, else → STOP.
  - PARITY: capture bit. Error if even mode and XOR(data, bit) ≠ 0, or odd mode and XOR(data, bit) ≠ 1.
  - STOP: evaluate each stop bit at its bit end.
    - Stop bit majority 0: terminate immediately with `o_frame_err` = 1.
    - `o_break` = 1 additionally if data and the parity bit (if any) were all 0.
    - After any frame error → WAIT_IDLE, so no restart until line is high.
    - After the last good stop bit → IDLE.
- Frame completion:
  - `o_data`, `o_parity_err`, `o_frame_err` and `o_break` update together with the `o_valid` pulse.
  - These outputs hold until the next completion.
  - Parity error alone does not suppress `o_valid`.

## Timing
- All outputs reset to 0. State resets to WAIT_IDLE. `s` and `n` reset to 0.
- `o_valid` is asserted on the clk edge after the tick ending the final stop bit, or the erroring stop bit. It is high for exactly 1 cycle.
- Start detection latency: 2 clk (synchronizer) + ≤DVSR clk (tick alignment). Resulting sample jitter is ≤1 tick.
- Frame duration in ticks: OVS × (1 + dbit + parity + stops).
- `o_busy` rises on the IDLE→START transition. It falls on the transition to IDLE.
- `o_busy` stays high during WAIT_IDLE.
- Reset asserted mid-frame: all state clears immediately, and no `o_valid` is produced for that frame.
- If `rx_s` is low at reset release, the block stays in WAIT_IDLE until the line goes high.
- Back-to-back frames: a start bit beginning on the tick immediately after the last stop-bit end is accepted.

## Test plan
Bench uses `DVSR` = 4, `OVS` = 16 (64 clk/bit), `DBIT_MAX` = 8.
- 8N1 frame 0x22 → one `o_valid`, `o_data` = 0x22, all error flags 0.
- 7E2 frame 0x07 with parity bit 1 → `o_data` = 0x07, `o_parity_err` = 0. Same frame with parity bit 0 → `o_valid`, `o_data` = 0x07, `o_parity_err` = 1.
- 5O1 frame 0x03 with parity bit 1 → `o_data` = 0x03, upper 3 bits 0, no errors. Then `i_cfg_dbit` = 2 → frame decoded as 5 data bits.
- Break: `i_rx` low for 20 bit times, 8N1 → exactly one `o_valid`, `o_data` = 0, `o_frame_err` = 1, `o_break` = 1. No further pulses while low. After line high, 0x55 frame → `o_data` = 0x55, flags 0.
- Noise:
  - `i_rx` low for 5 ticks only → no `o_valid`, `o_busy` returns to 0.
  - 1-tick glitch at the centre of data bit 1 of 0xA5 → `o_data` = 0xA5.
- Reset pulse at data bit 4 of a frame, released while `i_rx` low → no `o_valid` for the cut frame. Next clean frame 0x3C → `o_data` = 0x3C.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with 3-sample majority voting,
// parity/frame/break detection and an integrated baud-tick generator.
module uart_rx_cfg #(
   parameter int unsigned DBIT_MAX = 8,
   parameter int unsigned OVS      = 16,
   parameter int unsigned DVSR     = 326,
   parameter int unsigned DVSR_BIT = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_rx,
   input  logic [3:0]          i_cfg_dbit,
   input  logic [1:0]          i_cfg_parity,
   input  logic                i_cfg_stop,
   output logic [DBIT_MAX-1:0] o_data,
   output logic                o_valid,
   output logic                o_parity_err,
   output logic                o_frame_err,
   output logic                o_break,
   output logic                o_busy
);

   localparam int unsigned S_W = (OVS > 1) ? $clog2(OVS) : 1;
   localparam logic [S_W-1:0]      S_LAST    = S_W'(OVS - 1);
   localparam logic [S_W-1:0]      S_SMP0    = S_W'(OVS / 2 - 1);
   localparam logic [S_W-1:0]      S_SMP1    = S_W'(OVS / 2);
   localparam logic [S_W-1:0]      S_SMP2    = S_W'(OVS / 2 + 1);
   localparam logic [DVSR_BIT-1:0] BAUD_LAST = DVSR_BIT'(DVSR - 1);
   localparam logic [3:0]          DBIT_MIN  = 4'd5;
   localparam logic [3:0]          DBIT_TOP  = 4'(DBIT_MAX);
   localparam logic [1:0]          PAR_NONE  = 2'b00;
   localparam logic [1:0]          PAR_EVEN  = 2'b01;
   localparam logic [1:0]          PAR_ODD   = 2'b10;

   typedef enum logic [2:0] {
      ST_WAIT_IDLE = 3'd0,
      ST_IDLE      = 3'd1,
      ST_START     = 3'd2,
      ST_DATA      = 3'd3,
      ST_PARITY    = 3'd4,
      ST_STOP      = 3'd5
   } state_t;

   // synchronizer and baud generator
   logic                r_rx_meta, r_rx_s;
   logic [DVSR_BIT-1:0] r_baud;
   logic                w_tick;

   // frame state
   state_t              r_state, w_state_nx;
   logic [S_W-1:0]      r_s, w_s_nx;
   logic [3:0]          r_n, w_n_nx;
   logic [2:0]          r_smp, w_smp_nx;
   logic [DBIT_MAX-1:0] r_shift, w_shift_nx;
   logic [3:0]          r_dbit, w_dbit_nx;
   logic [1:0]          r_par_mode, w_par_mode_nx;
   logic                r_two_stop, w_two_stop_nx;
   logic                r_stop_idx, w_stop_idx_nx;
   logic                r_par_bit, w_par_bit_nx;
   logic                r_perr_pend, w_perr_pend_nx;

   // registered outputs
   logic [DBIT_MAX-1:0] r_data, w_data_nx;
   logic                r_valid, w_valid_nx;
   logic                r_perr, w_perr_nx;
   logic                r_ferr, w_ferr_nx;
   logic                r_brk, w_brk_nx;
   logic                r_busy, w_busy_nx;

   logic                w_maj;
   logic                w_bit_end;
   logic                w_xor;
   logic [3:0]          w_cfg_dbit;
   logic [1:0]          w_cfg_par;

   assign w_tick     = (r_baud == BAUD_LAST);
   assign w_maj      = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
   assign w_xor      = (^r_shift) ^ w_maj;
   assign w_cfg_dbit = (i_cfg_dbit < DBIT_MIN) ? DBIT_MIN :
                       (i_cfg_dbit > DBIT_TOP) ? DBIT_TOP : i_cfg_dbit;
   assign w_cfg_par  = (i_cfg_parity == 2'b11) ? PAR_NONE : i_cfg_parity;

   // line synchronizer (idle-high reset) and free-running baud counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_baud    <= '0;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
         r_baud    <= w_tick ? '0 : r_baud + DVSR_BIT'(1);
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_WAIT_IDLE;
         r_s         <= '0;
         r_n         <= '0;
         r_smp       <= '0;
         r_shift     <= '0;
         r_dbit      <= DBIT_MIN;
         r_par_mode  <= PAR_NONE;
         r_two_stop  <= 1'b0;
         r_stop_idx  <= 1'b0;
         r_par_bit   <= 1'b0;
         r_perr_pend <= 1'b0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_perr      <= 1'b0;
         r_ferr      <= 1'b0;
         r_brk       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_s         <= w_s_nx;
         r_n         <= w_n_nx;
         r_smp       <= w_smp_nx;
         r_shift     <= w_shift_nx;
         r_dbit      <= w_dbit_nx;
         r_par_mode  <= w_par_mode_nx;
         r_two_stop  <= w_two_stop_nx;
         r_stop_idx  <= w_stop_idx_nx;
         r_par_bit   <= w_par_bit_nx;
         r_perr_pend <= w_perr_pend_nx;
         r_data      <= w_data_nx;
         r_valid     <= w_valid_nx;
         r_perr      <= w_perr_nx;
         r_ferr      <= w_ferr_nx;
         r_brk       <= w_brk_nx;
         r_busy      <= w_busy_nx;
      end
   end

   // next-state, bit sampling and frame-completion logic
   always_comb begin
      w_state_nx     = r_state;
      w_s_nx         = r_s;
      w_n_nx         = r_n;
      w_smp_nx       = r_smp;
      w_shift_nx     = r_shift;
      w_dbit_nx      = r_dbit;
      w_par_mode_nx  = r_par_mode;
      w_two_stop_nx  = r_two_stop;
      w_stop_idx_nx  = r_stop_idx;
      w_par_bit_nx   = r_par_bit;
      w_perr_pend_nx = r_perr_pend;
      w_data_nx      = r_data;
      w_valid_nx     = 1'b0;
      w_perr_nx      = r_perr;
      w_ferr_nx      = r_ferr;
      w_brk_nx       = r_brk;
      w_bit_end      = 1'b0;

      // oversampling counter and mid-bit samples while inside a frame
      if (w_tick && (r_state != ST_WAIT_IDLE) && (r_state != ST_IDLE)) begin
         if (r_s == S_SMP0) w_smp_nx[0] = r_rx_s;
         if (r_s == S_SMP1) w_smp_nx[1] = r_rx_s;
         if (r_s == S_SMP2) w_smp_nx[2] = r_rx_s;
         if (r_s == S_LAST) begin
            w_s_nx    = '0;
            w_bit_end = 1'b1;
         end else begin
            w_s_nx = r_s + S_W'(1);
         end
      end

      case (r_state)
         ST_WAIT_IDLE: begin
            if (w_tick && r_rx_s) w_state_nx = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_tick && !r_rx_s) begin
               w_state_nx     = ST_START;
               w_s_nx         = '0;
               w_dbit_nx      = w_cfg_dbit;
               w_par_mode_nx  = w_cfg_par;
               w_two_stop_nx  = i_cfg_stop;
               w_par_bit_nx   = 1'b0;
               w_perr_pend_nx = 1'b0;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               if (w_maj) begin
                  w_state_nx = ST_IDLE;
               end else begin
                  w_state_nx = ST_DATA;
                  w_n_nx     = '0;
                  w_shift_nx = '0;
               end
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_shift_nx = r_shift | (DBIT_MAX'(w_maj) << r_n);
               if (r_n == r_dbit - 4'd1) begin
                  w_n_nx        = '0;
                  w_stop_idx_nx = 1'b0;
                  w_state_nx    = (r_par_mode == PAR_NONE) ? ST_STOP : ST_PARITY;
               end else begin
                  w_n_nx = r_n + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_end) begin
               w_par_bit_nx   = w_maj;
               w_perr_pend_nx = (r_par_mode == PAR_EVEN) ? w_xor : ~w_xor;
               w_state_nx     = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_bit_end) begin
               if (!w_maj) begin
                  w_valid_nx = 1'b1;
                  w_data_nx  = r_shift;
                  w_perr_nx  = r_perr_pend;
                  w_ferr_nx  = 1'b1;
                  w_brk_nx   = (r_shift == '0) && !r_par_bit;
                  w_state_nx = ST_WAIT_IDLE;
               end else if (r_two_stop && !r_stop_idx) begin
                  w_stop_idx_nx = 1'b1;
               end else begin
                  w_valid_nx = 1'b1;
                  w_data_nx  = r_shift;
                  w_perr_nx  = r_perr_pend;
                  w_ferr_nx  = 1'b0;
                  w_brk_nx   = 1'b0;
                  w_state_nx = ST_IDLE;
               end
            end
         end
         default: w_state_nx = ST_WAIT_IDLE;
      endcase

      w_busy_nx = (w_state_nx != ST_IDLE);
   end

   assign o_data       = r_data;
   assign o_valid      = r_valid;
   assign o_parity_err = r_perr;
   assign o_frame_err  = r_ferr;
   assign o_break      = r_brk;
   assign o_busy       = r_busy;

endmodule
